// File: rtl/imm_pkg.sv
// Shared constants and helpers for the immediate-generator family.
// Format-select encodings are common to the pipelined block and any single-cycle core.
package imm_pkg;

  localparam int unsigned SRC_W   = 3;
  localparam int unsigned INSTR_W = 32;

  localparam logic [SRC_W-1:0] IMM_I = 3'd0;
  localparam logic [SRC_W-1:0] IMM_S = 3'd1;
  localparam logic [SRC_W-1:0] IMM_B = 3'd2;
  localparam logic [SRC_W-1:0] IMM_U = 3'd3;
  localparam logic [SRC_W-1:0] IMM_J = 3'd4;
  localparam logic [SRC_W-1:0] IMM_Z = 3'd5;

  // Encodings above IMM_Z are reserved and flagged as illegal.
  function automatic logic is_legal_src(input logic [SRC_W-1:0] src);
    return src <= IMM_Z;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32/RV64 immediate decoder: I, S, B, U, J and CSR zimm.
// Builds a 32-bit result, then widens it by repeating bit 31 up to XLEN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [SRC_W-1:0]   src,
  output logic [XLEN-1:0]    value,
  output logic               illegal
);

  logic [INSTR_W-1:0] word;
  logic               s;
  logic               unused_opcode;

  assign s             = instr[31];
  assign unused_opcode = ^instr[6:0];

  // Field scatter per format; zimm and illegal leave bit 31 clear so widening stays correct.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (src)
      IMM_I:   word = {{20{s}}, instr[31:20]};
      IMM_S:   word = {{20{s}}, instr[31:25], instr[11:7]};
      IMM_B:   word = {{19{s}}, s, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   word = {instr[31:12], 12'b0};
      IMM_J:   word = {{11{s}}, s, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_Z:   word = {27'b0, instr[19:15]};
      default: illegal = 1'b1;
    endcase
  end

  if (XLEN == 32) begin : g_x32
    assign value = word;
  end else begin : g_wide
    localparam int unsigned EXT_W = XLEN - 32;
    assign value = {{EXT_W{word[31]}}, word};
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake and a 2-entry skid buffer.
// The main entry drives the outputs; the skid entry absorbs one result while the consumer stalls.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SRC_W = imm_pkg::SRC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      In,
  input  logic [SRC_W-1:0] ImmSrc,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [XLEN-1:0]  Imm_Ext,
  output logic             Illegal,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [XLEN-1:0] dec_value;
  logic            dec_illegal;
  logic [XLEN-1:0] skid_imm;
  logic            skid_ill;
  logic            in_fire;
  logic            out_fire;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr  (In),
    .src    (imm_pkg::SRC_W'(ImmSrc)),
    .value  (dec_value),
    .illegal(dec_illegal)
  );

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Main entry plus occupancy; in_ready is the registered "skid empty" flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      Imm_Ext   <= '0;
      Illegal   <= 1'b0;
    end else if (!out_valid) begin
      if (in_fire) begin
        out_valid <= 1'b1;
        Imm_Ext   <= dec_value;
        Illegal   <= dec_illegal;
      end
    end else if (out_fire) begin
      if (!in_ready) begin
        Imm_Ext  <= skid_imm;
        Illegal  <= skid_ill;
        in_ready <= 1'b1;
      end else if (in_fire) begin
        Imm_Ext <= dec_value;
        Illegal <= dec_illegal;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      in_ready <= 1'b0;
    end
  end

  // Skid payload is only read while its flag is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_fire && out_valid && !out_ready) begin
      skid_imm <= dec_value;
      skid_ill <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe at XLEN=32 and XLEN=64 driven in lockstep.
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] In;
  logic [2:0]  ImmSrc;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;

  exp_t        cur_exp;
  exp_t        q32[$];
  exp_t        q64[$];
  int          n_tests;
  int          n_fail;
  logic        hold32, hold64;
  logic [32:0] held32;
  logic [64:0] held64;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .In(In), .ImmSrc(ImmSrc), .in_valid(in_valid),
    .in_ready(in_ready32), .Imm_Ext(imm32), .Illegal(ill32),
    .out_valid(out_valid32), .out_ready(out_ready)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .In(In), .ImmSrc(ImmSrc), .in_valid(in_valid),
    .in_ready(in_ready64), .Imm_Ext(imm64), .Illegal(ill64),
    .out_valid(out_valid64), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] imm, input logic ill);
    exp_t r;
    r.imm = imm;
    r.ill = ill;
    return r;
  endfunction

  // Reference: immediates assembled arithmetically from the ISA field definitions.
  function automatic exp_t model(input logic [31:0] w, input logic [2:0] src);
    longint sw;
    longint v;
    exp_t   r;
    sw    = longint'($signed(w));
    v     = 0;
    r.ill = 1'b0;
    case (src)
      3'd0: v = sw >>> 20;
      3'd1: v = ((sw >>> 25) << 5) | longint'(w[11:7]);
      3'd2: v = ((sw >>> 31) << 12) | (longint'(w[7]) << 11)
              | (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
      3'd3: v = longint'($signed(w & 32'hFFFF_F000));
      3'd4: v = ((sw >>> 31) << 20) | (longint'(w[19:12]) << 12)
              | (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
      3'd5: v = longint'(w[19:15]);
      default: r.ill = 1'b1;
    endcase
    r.imm = 64'(v);
    return r;
  endfunction

  // Issue side: record the expected result whenever an input is accepted.
  always @(negedge clk) begin
    if (rst) begin
      if (in_valid && in_ready32) q32.push_back(cur_exp);
      if (in_valid && in_ready64) q64.push_back(cur_exp);
    end
  end

  // Output monitor: stability while stalled, ordered compare on every transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      q32.delete();
      q64.delete();
      hold32 = 1'b0;
      hold64 = 1'b0;
    end else begin
      check("hs_match", {in_ready64, out_valid64}, {in_ready32, out_valid32});
      if (out_valid32) begin
        if (hold32) check("stable32", 64'({ill32, imm32}), 64'(held32));
        if (out_ready) begin
          if (q32.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL spurious32 got %h expected no output", imm32);
          end else begin
            e = q32.pop_front();
            check("imm32", 64'(imm32), 64'(e.imm[31:0]));
            check("ill32", 64'(ill32), 64'(e.ill));
          end
          hold32 = 1'b0;
        end else begin
          hold32 = 1'b1;
          held32 = {ill32, imm32};
        end
      end else begin
        hold32 = 1'b0;
      end
      if (out_valid64) begin
        if (hold64) check("stable64", imm64, held64[63:0]);
        if (out_ready) begin
          if (q64.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL spurious64 got %h expected no output", imm64);
          end else begin
            e = q64.pop_front();
            check("imm64", imm64, e.imm);
            check("ill64", 64'(ill64), 64'(e.ill));
          end
          hold64 = 1'b0;
        end else begin
          hold64 = 1'b1;
          held64 = {ill64, imm64};
        end
      end else begin
        hold64 = 1'b0;
      end
    end
  end

  // Present one input and hold it until accepted; returns 2 ns after the accepting edge.
  task automatic drive(input logic [31:0] w, input logic [2:0] src, input exp_t e, output int waits);
    logic acc;
    In       = w;
    ImmSrc   = src;
    cur_exp  = e;
    in_valid = 1'b1;
    waits    = 0;
    forever begin
      @(negedge clk);
      acc = in_ready32;
      @(posedge clk);
      #2;
      if (acc) return;
      waits++;
      if (waits > 200) begin
        n_tests++; n_fail++;
        $display("FAIL accept_timeout got no accept expected accept within 200 cycles");
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int w;
    int budget;
    logic [31:0] rw;
    logic [2:0]  rs;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    In        = '0;
    ImmSrc    = '0;
    cur_exp   = '0;
    #1 rst = 1'b0;
    #1;
    check("rst_out_valid", 64'({out_valid32, out_valid64}), 64'd0);
    check("rst_in_ready", 64'({in_ready32, in_ready64}), 64'd3);
    check("rst_imm32", 64'(imm32), 64'd0);
    check("rst_imm64", imm64, 64'd0);
    check("rst_illegal", 64'({ill32, ill64}), 64'd0);
    #20;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #2;

    // Directed formats with hand-derived results.
    out_ready = 1'b1;
    drive(32'hFFC12083, 3'd0, mk(64'hFFFF_FFFF_FFFF_FFFC, 1'b0), w);
    in_valid = 1'b0;
    check("latency_I", 64'({out_valid32, out_valid64}), 64'd3);
    idle(2);
    drive(32'hFE112E23, 3'd1, mk(64'hFFFF_FFFF_FFFF_FFFC, 1'b0), w);
    check("b2b_S_valid", 64'(out_valid32), 64'd1);
    drive(32'hFE000CE3, 3'd2, mk(64'hFFFF_FFFF_FFFF_FFF8, 1'b0), w);
    check("b2b_B_valid", 64'(out_valid32), 64'd1);
    check("b2b_B_value", 64'(imm32), 64'h0000_0000_FFFF_FFF8);
    drive(32'h123450B7, 3'd3, mk(64'h0000_0000_1234_5000, 1'b0), w);
    drive(32'h0010006F, 3'd4, mk(64'h0000_0000_0000_0800, 1'b0), w);
    drive(32'h800F8073, 3'd5, mk(64'h0000_0000_0000_001F, 1'b0), w);
    drive(32'hFFFFFFFF, 3'd7, mk(64'h0, 1'b1), w);
    drive(32'h800000B7, 3'd3, mk(64'hFFFF_FFFF_8000_0000, 1'b0), w);
    idle(3);

    // Back-pressure: two accepted, third waits until the consumer drains.
    out_ready = 1'b0;
    drive(32'hFFC12083, 3'd0, mk(64'hFFFF_FFFF_FFFF_FFFC, 1'b0), w);
    drive(32'hFE000CE3, 3'd2, mk(64'hFFFF_FFFF_FFFF_FFF8, 1'b0), w);
    check("bp_ready_low", 64'({in_ready32, in_ready64}), 64'd0);
    In       = 32'h0010006F;
    ImmSrc   = 3'd4;
    cur_exp  = mk(64'h800, 1'b0);
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("bp_still_full", 64'({in_ready32, out_valid32}), 64'd1);
    check("bp_head_value", 64'(imm32), 64'h0000_0000_FFFF_FFFC);
    out_ready = 1'b1;
    drive(32'h0010006F, 3'd4, mk(64'h800, 1'b0), w);
    idle(4);

    // Asynchronous reset with both entries occupied.
    out_ready = 1'b0;
    drive(32'h123450B7, 3'd3, mk(64'h1234_5000, 1'b0), w);
    drive(32'hFE112E23, 3'd1, mk(64'hFFFF_FFFF_FFFF_FFFC, 1'b0), w);
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_out_valid", 64'({out_valid32, out_valid64}), 64'd0);
    check("arst_in_ready", 64'({in_ready32, in_ready64}), 64'd3);
    check("arst_imm", imm64 | 64'(imm32), 64'd0);
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drive(32'h0010006F, 3'd4, mk(64'h800, 1'b0), w);
    check("first_accept_waits", 64'(w), 64'd0);
    idle(2);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      rw        = $urandom;
      rs        = 3'($urandom_range(0, 7));
      out_ready = ($urandom % 4) != 0;
      In        = rw;
      ImmSrc    = rs;
      cur_exp   = model(rw, rs);
      in_valid  = ($urandom % 4) != 0;
      @(posedge clk);
      #2;
    end

    // Drain with a bounded wait.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget    = 0;
    while ((q32.size() != 0 || q64.size() != 0 || out_valid32) && budget < 50) begin
      @(posedge clk);
      #2;
      budget++;
    end
    check("drain_q32", 64'(q32.size()), 64'd0);
    check("drain_q64", 64'(q64.size()), 64'd0);
    check("drain_idle", 64'({out_valid32, out_valid64, in_ready32, in_ready64}), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate generator. Successor to the combinational two-mode sign extender.
- Decodes all RV32/RV64 base immediate formats (I, S, B, U, J) plus the CSR zimm field, and sign- or zero-extends the result to XLEN.
- Sits between decode and execute. Includes a valid/ready handshake and a 2-entry skid buffer, so it sustains one instruction per cycle under back-pressure.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- SRC_W, 3, width of ImmSrc select.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- In  input  32  raw instruction word.
- ImmSrc  input  SRC_W  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (CSR zimm), 110/111 illegal.
- in_valid  input  1  In/ImmSrc valid this cycle.
- in_ready  output  1  block can accept.
- Imm_Ext  output  XLEN  extended immediate.
- Illegal  output  1  ImmSrc was 110/111 for the presented result.
- out_valid  output  1  Imm_Ext/Illegal valid.
- out_ready  input  1  consumer accepts.

Behaviour:
- Decode (combinational, s = In[31], extended by repeating s up to XLEN):
  - I: {s.., In[31:20]}
  - S: {s.., In[31:25], In[11:7]}
  - B: {s.., In[7], In[30:25], In[11:8], 1'b0}, with s at bit 12
  - U: {s.. (bits XLEN-1:32, only when XLEN=64), In[31:12], 12'b0}
  - J: {s.., In[19:12], In[20], In[30:21], 1'b0}
  - Z: zero-extend In[19:15]
  - illegal: value 0, Illegal=1
- Storage: main register M (valid bit mv) drives the outputs; skid register K (valid bit kv). Each entry holds {Imm_Ext, Illegal}.
- Handshake signals:
  - in_ready = !kv. It depends only on state, never combinationally on out_ready.
  - out_valid = mv.
  - in_fire = in_valid & in_ready.
  - out_fire = mv & out_ready.
- Per-cycle update:
  - !mv: on in_fire, M <= decode, mv <= 1.
  - mv & out_fire & kv: M <= K, kv <= 0. No input is possible because in_ready=0.
  - mv & out_fire & !kv: on in_fire, M <= decode (mv stays 1); otherwise mv <= 0.
  - mv & !out_fire & in_fire: K <= decode, kv <= 1.
  - mv & !out_fire & !in_fire: hold.
- Latency: 1 cycle from in_fire to out_valid when empty. Throughput: 1/cycle with out_ready held high.
- Ordering: strict FIFO. Results never drop or duplicate.
- Stability: while out_valid & !out_ready, Imm_Ext and Illegal hold stable.
- Reset (rst=0, asynchronous): mv=0, kv=0, Imm_Ext=0, Illegal=0, out_valid=0, in_ready=1.
  - Reset mid-operation discards both entries immediately.
  - First accept is possible on the first clock edge after rst deasserts.
- Data regs need no reset beyond the outputs, but Imm_Ext/Illegal must read 0 while mv=0 after reset.
- Changing In or ImmSrc while in_valid=0 has no effect on state.

Decomposition:
- Shared package imm_pkg:
  - ImmSrc localparams IMM_I=0, IMM_S=1, IMM_B=2, IMM_U=3, IMM_J=4, IMM_Z=5.
  - SRC_W constant.
- Sub-module imm_decode: purely combinational (In, ImmSrc → value, illegal), parametrised by XLEN. Shared with any future single-cycle core.
- Top module contains only the skid/handshake logic.

Test Plan:
- I: In=0xFFC12083, ImmSrc=000, out_ready=1 → Imm_Ext=0xFFFFFFFC one cycle later, Illegal=0.
- S/B, back-to-back:
  - S: 0xFE112E23 → 0xFFFFFFFC.
  - B: 0xFE000CE3 → 0xFFFFFFF8.
  - Both returned on consecutive cycles.
- U/J/Z:
  - U: 0x123450B7 → 0x12345000.
  - J: 0x0010006F → 0x00000800.
  - Z: In[19:15]=5'h1F → 0x0000001F.
  - ImmSrc=111 → Imm_Ext=0, Illegal=1.
- Back-pressure: hold out_ready=0 and send 3 valid inputs.
  - 2 are accepted, and in_ready drops after the 2nd.
  - Outputs stay stable.
  - Releasing out_ready delivers them in order, then the 3rd.
- Reset: assert rst=0 asynchronously mid-cycle with both entries full → out_valid=0, in_ready=1 immediately, Imm_Ext=0.
- XLEN=64: I with 0xFFC12083 → 0xFFFFFFFFFFFFFFFC; U with 0x800000B7 → 0xFFFFFFFF80000000.
